// File: rtl/ray_dispatcher_if.sv
// Generator-side ray stream between the ray generator and ray_dispatcher.
// The generator drives the master modport and the dispatcher uses the slave
// modport. Each inV component is a two's-complement value of POSITION_WIDTH
// bits; the dispatcher passes it through bit-exact.
interface ray_dispatcher_if #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32
);
  logic [2:0][POSITION_WIDTH-1:0] inV;
  logic [ADDRESS_WIDTH-1:0]       inAddress;
  logic                           inStart;
  logic                           inReady;
  logic                           busy;

  modport master (
    output inV,
    output inAddress,
    output inStart,
    input  inReady,
    input  busy
  );

  modport slave (
    input  inV,
    input  inAddress,
    input  inStart,
    output inReady,
    output busy
  );
endinterface

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: buffers one camera ray from the generator and hands it to a
// free ray unit. Units are chosen round-robin and receive a one-cycle start pulse.
// The registered start mask stops the unit that was just started from being
// granted again in the next cycle, before it has had time to drop unitReady.
// Optional feature macro: RAY_DISPATCH_STATS_EN adds per-unit dispatch
// counters on the dispatchCount output.
module ray_dispatcher #(
  parameter int UNITS          = 4,
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32
) (
  input  logic                           clock,
  input  logic                           resetN,
  ray_dispatcher_if.slave                gen,
  input  logic [UNITS-1:0]               unitEnable,
  output logic [2:0][POSITION_WIDTH-1:0] unitV,
  output logic [ADDRESS_WIDTH-1:0]       unitAddress,
  output logic [UNITS-1:0]               unitStart,
  input  logic [UNITS-1:0]               unitReady,
  input  logic [UNITS-1:0]               unitBusy
`ifdef RAY_DISPATCH_STATS_EN
  ,
  output logic [UNITS-1:0][31:0]         dispatchCount
`endif
);

  localparam int PTR_W = $clog2(UNITS);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t                     state_r;
  buf_state_t                     state_next_s;
  logic [PTR_W-1:0]               rr_ptr_r;
  logic [PTR_W-1:0]               grant_idx_s;
  logic [PTR_W-1:0]               rr_ptr_next_s;
  logic [UNITS-1:0]               eligible_s;
  logic [UNITS-1:0]               grant_onehot_s;
  logic                           dispatch_s;
  logic                           accept_s;
  logic                           in_ready_s;
  logic                           busy_s;
  logic [2:0][POSITION_WIDTH-1:0] buf_v_r;
  logic [ADDRESS_WIDTH-1:0]       buf_addr_r;
  logic [UNITS-1:0]               unit_start_r;
  logic [2:0][POSITION_WIDTH-1:0] unit_v_r;
  logic [ADDRESS_WIDTH-1:0]       unit_addr_r;

  // First set bit of elig at or after ptr, searching upward modulo UNITS.
  // Scanning from the far end lets the nearest candidate win the last write.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [UNITS-1:0] elig,
    input logic [PTR_W-1:0] ptr
  );
    logic [PTR_W-1:0] pick;
    int               idx;
    pick = {PTR_W{1'b0}};
    for (int i = UNITS - 1; i >= 0; i--) begin
      idx  = (int'(ptr) + i) % UNITS;
      pick = elig[idx[PTR_W-1:0]] ? idx[PTR_W-1:0] : pick;
    end
    return pick;
  endfunction

  assign eligible_s     = unitReady & unitEnable & ~unit_start_r;
  assign dispatch_s     = (state_r == FULL) && (eligible_s != {UNITS{1'b0}});
  assign grant_idx_s    = rr_pick(eligible_s, rr_ptr_r);
  assign grant_onehot_s = {{(UNITS-1){1'b0}}, 1'b1} << grant_idx_s;
  assign rr_ptr_next_s  = (grant_idx_s == PTR_W'(UNITS - 1)) ? {PTR_W{1'b0}}
                                                             : grant_idx_s + PTR_W'(1);

  // The generator advances its pipeline on inReady, so inReady has to be
  // combinational. It also covers the slot that a same-cycle dispatch frees.
  assign in_ready_s = resetN && ((state_r == EMPTY) || dispatch_s);
  assign accept_s   = gen.inStart && in_ready_s;
  assign busy_s     = (state_r == FULL) || (|unit_start_r) || (|unitBusy);

  assign gen.inReady = in_ready_s;
  assign gen.busy    = busy_s;
  assign unitStart   = unit_start_r;
  assign unitV       = unit_v_r;
  assign unitAddress = unit_addr_r;

  // Holding-register occupancy state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next occupancy. A FULL buffer stays FULL when a dispatch and an accept
  // happen together, because the new ray takes the slot being emptied.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (dispatch_s && !accept_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // Capture an accepted ray. This overwrites the entry that is being dispatched.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      buf_v_r    <= {(3*POSITION_WIDTH){1'b0}};
      buf_addr_r <= {ADDRESS_WIDTH{1'b0}};
    end else if (accept_s) begin
      buf_v_r    <= gen.inV;
      buf_addr_r <= gen.inAddress;
    end
  end

  // Issue the start pulse, drive the shared unit bus and advance the pointer.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      unit_start_r <= {UNITS{1'b0}};
      unit_v_r     <= {(3*POSITION_WIDTH){1'b0}};
      unit_addr_r  <= {ADDRESS_WIDTH{1'b0}};
      rr_ptr_r     <= {PTR_W{1'b0}};
    end else if (dispatch_s) begin
      unit_start_r <= grant_onehot_s;
      unit_v_r     <= buf_v_r;
      unit_addr_r  <= buf_addr_r;
      rr_ptr_r     <= rr_ptr_next_s;
    end else begin
      unit_start_r <= {UNITS{1'b0}};
    end
  end

`ifdef RAY_DISPATCH_STATS_EN
  logic [UNITS-1:0][31:0] dispatch_count_r;

  // Count each unit's start pulses on the edge that issues them.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dispatch_count_r <= {(UNITS*32){1'b0}};
    end else if (dispatch_s) begin
      dispatch_count_r[grant_idx_s] <= dispatch_count_r[grant_idx_s] + 32'd1;
    end
  end

  assign dispatchCount = dispatch_count_r;
`endif

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Distributes camera rays from the ray generator's output stream across `UNITS` parallel ray units. It sits between the generator's `rayV`/`rayAddress`/`rayStart`/`rayReady`/`rayBusy` port and the ray-unit array. It buffers one ray, picks a free unit round-robin, and issues a one-cycle start pulse. It also reports aggregate readiness and busy status back to the generator.

## Interface
- `UNITS`, 4: number of ray units, 2..16.
- `POSITION_WIDTH`, 16: signed width of each ray-vector component.
- `ADDRESS_WIDTH`, 32: pixel address width.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `inV`  in  `[POSITION_WIDTH-1:0]` ×3 signed  ray direction from the generator.
- `inAddress`  in  `ADDRESS_WIDTH`  pixel address from the generator.
- `inStart`  in  1  ray valid from the generator.
- `inReady`  out  1  ray consumed this cycle; drives the generator's `rayReady`.
- `busy`  out  1  ray held, in flight, or any unit busy; drives the generator's `rayBusy`.
- `unitEnable`  in  `UNITS`  per-unit enable mask; a disabled unit is never granted.
- `unitV`  out  `[POSITION_WIDTH-1:0]` ×3 signed  shared ray bus to all units.
- `unitAddress`  out  `ADDRESS_WIDTH`  shared address bus.
- `unitStart`  out  `UNITS`  one-hot start pulse, at most one bit high per cycle.
- `unitReady`  in  `UNITS`  unit can accept a ray.
- `unitBusy`  in  `UNITS`  unit is processing.

## Operation
- **Holding register:** a single-entry buffer with two states.
  - EMPTY → FULL on `inStart && inReady` when no dispatch occurs.
  - FULL → EMPTY on dispatch without a new accept.
  - FULL → FULL on simultaneous dispatch and accept; the new ray overwrites the register.
- **`inReady`:** `resetN && (EMPTY || dispatch this cycle)`. It is combinational, because the generator advances its pipeline on `rayReady`.
- **Eligibility:** `eligible = unitReady & unitEnable & ~unitStart`. The registered `unitStart` mask blocks re-granting a unit in the cycle after its pulse.
- **Unit contract:** a unit must drop `unitReady` no later than the cycle after it sees `unitStart`.
- **Dispatch:** occurs when the buffer is FULL and `eligible != 0`. The grant is the first eligible index at or after `rrPtr`, searching upward modulo `UNITS`.
- **On dispatch, the next edge performs all of the following:**
  - `unitStart[g]` is set to 1; all other bits are 0.
  - `unitV` and `unitAddress` are loaded from the buffer.
  - `rrPtr` becomes `(g+1) mod UNITS`.
- **Without a dispatch:** `unitStart` returns to 0, and `unitV`/`unitAddress` hold their last values.
- **No eligible unit:** the buffer stays FULL, `inReady` is 0, and the generator stalls.
- **`busy`:** `FULL || |unitStart || |unitBusy`.
- **Enable changes:** `unitEnable` may change at any time and takes effect on the next grant decision. Clearing a unit's enable does not cancel a start pulse that is already issued.

## Timing
- **Reset values (asynchronous assert, synchronous release):**
  - Buffer EMPTY, `rrPtr` 0.
  - `unitStart` 0; `unitV` 0; `unitAddress` 0.
  - `busy` 0, or `|unitBusy` if units report busy.
  - `inReady` 0 while `resetN` is low.
- **Latency:** a ray accepted at edge t is in the buffer after t. With an eligible unit, its `unitStart` is high in cycle t+1 (registered at edge t+1).
- **Throughput:** one ray per cycle while a different eligible unit exists each cycle. A single enabled unit gets at most one ray every 2 cycles because of the mask.
- **Reset mid-operation:** a buffered ray is dropped, and `unitStart` clears immediately. Units are reset separately.
- **Arithmetic:** vector and address are passed through bit-exact with no arithmetic. `rrPtr` is `$clog2(UNITS)` bits and wraps at `UNITS-1` → 0, including for non-power-of-two `UNITS`.

## Configuration
- **`RAY_DISPATCH_STATS_EN` defined:** adds output `dispatchCount` (32 bits × `UNITS`). Element i increments on each edge where `unitStart[i]` is set. It wraps modulo 2^32, clears on reset, and adds no latency.
- **Undefined:** the port and counters are absent, and all other behaviour is identical.

## Test plan
- **Round-robin:** `UNITS`=4, all ready and enabled, generator streams 8 rays (addresses 0..7) back-to-back. Expect `unitStart` order 0,1,2,3,0,1,2,3 on consecutive cycles, `inReady` held at 1, and `unitAddress` matching each pulse.
- **Backpressure:** all `unitReady`=0 with a ray presented at address 0x100. Expect the buffer FULL, `inReady`=0 and `busy`=1 for 20 cycles. Then raise `unitReady[2]` only: expect `unitStart`=4'b0100 with address 0x100 one cycle later, then `inReady`=1.
- **Single-unit mask:** `unitEnable`=4'b0010, `unitReady[1]` toggling per the unit contract, 4 rays. Expect every pulse on unit 1 only, spaced by 2 or more cycles, and no pulse to a disabled unit.
- **Skid/overwrite:** buffer FULL, dispatch and `inStart` in the same cycle with inV={5,-3,7}. Expect the next dispatched `unitV`={5,-3,7}, with no ray lost or duplicated (count 10 rays in, 10 pulses out).
- **Reset mid-stream:** assert `resetN`=0 asynchronously while the buffer is FULL and `unitStart` is high. Expect `unitStart`=0 and `inReady`=0 in the same cycle; after release, the first grant goes to unit 0.
- **Stats (`RAY_DISPATCH_STATS_EN`):** 9 rays, 3 units all ready. Expect `dispatchCount`={3,3,3}, and all zero after reset.
